// File: rtl/axi_fb_pkg.sv
// Shared types and constants for the camera frame-buffer AXI write responder.
package axi_fb_pkg;
  localparam int AXI_DW = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_t;
endpackage

// File: rtl/axi_fb_if.sv
// AXI4 write-channel bundle (AW, W, B) between the camera DMA and the frame buffer.
interface axi_fb_if;
  import axi_fb_pkg::*;

  logic [31:0]       AWADDR;
  logic [7:0]        AWLEN;
  logic              AWVALID;
  logic              AWREADY;
  logic [AXI_DW-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic              WLAST;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output AWADDR, AWLEN, AWVALID, WDATA, WVALID, WLAST, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWLEN, AWVALID, WDATA, WVALID, WLAST, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/fb_ram.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read-first read port.
module fb_ram
  import axi_fb_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AXI_DW-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AXI_DW-1:0]        rdata
);
  logic [AXI_DW-1:0] mem [DEPTH];
  logic [AXI_DW-1:0] rdata_reg;

  // Storage array; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read: sees the pre-write value on a same-address collision, holds when idle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;
endmodule

// File: rtl/axi_frame_buffer_slave.sv
// Write-only AXI4 responder: one INCR burst at a time into the frame buffer,
// one B response per burst, frame_done pulse every FRAME_WORDS good words.
module axi_frame_buffer_slave
  import axi_fb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH       = 1024,
  parameter int          FRAME_WORDS = 1024
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  axi_fb_if.slave                  axi,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [AXI_DW-1:0]        rd_data,
  output logic                     frame_done
);
  localparam int AW = $clog2(DEPTH);

  state_t        state_reg, state_next;
  logic          awready_reg, awready_next;
  logic          wready_reg, wready_next;
  logic          bvalid_reg, bvalid_next;
  resp_t         bresp_reg, bresp_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [7:0]    len_reg, len_next;
  logic [7:0]    beat_reg, beat_next;
  logic          err_reg, err_next;
  logic [31:0]   words_cnt_reg, words_cnt_next;
  logic          frame_done_reg, frame_done_next;

  // Range check of the incoming burst, done in 33 bits so the end index cannot wrap.
  logic [29:0] aw_word;
  logic [32:0] aw_span;
  logic        aw_bad;
  assign aw_word = axi.AWADDR[31:2] - BASE_ADDR[31:2];
  assign aw_span = {3'b000, aw_word} + {25'd0, axi.AWLEN};
  assign aw_bad  = (axi.AWADDR < BASE_ADDR) || (axi.AWADDR[1:0] != 2'b00) ||
                   (aw_span >= 33'(DEPTH));

  logic aw_hs, w_hs, b_hs, beat_is_len, w_final, w_mismatch;
  assign aw_hs       = axi.AWVALID && awready_reg;
  assign w_hs        = axi.WVALID && wready_reg;
  assign b_hs        = bvalid_reg && axi.BREADY;
  assign beat_is_len = (beat_reg == len_reg);
  assign w_final     = w_hs && (axi.WLAST || beat_is_len);
  assign w_mismatch  = (axi.WLAST != beat_is_len);

  logic [31:0] words_sum;
  assign words_sum = words_cnt_reg + 32'(len_reg) + 32'd1;

  // State, handshake outputs and counters.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg      <= IDLE;
      awready_reg    <= 1'b0;
      wready_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
      bresp_reg      <= OKAY;
      idx_reg        <= '0;
      len_reg        <= '0;
      beat_reg       <= '0;
      err_reg        <= 1'b0;
      words_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      awready_reg    <= awready_next;
      wready_reg     <= wready_next;
      bvalid_reg     <= bvalid_next;
      bresp_reg      <= bresp_next;
      idx_reg        <= idx_next;
      len_reg        <= len_next;
      beat_reg       <= beat_next;
      err_reg        <= err_next;
      words_cnt_reg  <= words_cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Burst sequencing: address phase, data beats, then the held write response.
  always_comb begin
    state_next      = state_reg;
    awready_next    = awready_reg;
    wready_next     = wready_reg;
    bvalid_next     = bvalid_reg;
    bresp_next      = bresp_reg;
    idx_next        = idx_reg;
    len_next        = len_reg;
    beat_next       = beat_reg;
    err_next        = err_reg;
    words_cnt_next  = words_cnt_reg;
    frame_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        awready_next = 1'b1;
        if (aw_hs) begin
          awready_next = 1'b0;
          wready_next  = 1'b1;
          idx_next     = aw_word[AW-1:0];
          len_next     = axi.AWLEN;
          beat_next    = '0;
          err_next     = aw_bad;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_next = beat_reg + 8'd1;
          if (w_final) begin
            // A WLAST/length disagreement still closes the burst, but as SLVERR.
            err_next    = err_reg || w_mismatch;
            wready_next = 1'b0;
            bvalid_next = 1'b1;
            bresp_next  = (err_reg || w_mismatch) ? SLVERR : OKAY;
            state_next  = RESP;
          end
        end
      end
      RESP: begin
        if (b_hs) begin
          bvalid_next = 1'b0;
          state_next  = IDLE;
          if (bresp_reg == OKAY) begin
            // Overshoot past the frame size is dropped rather than carried.
            if (words_sum >= 32'(FRAME_WORDS)) begin
              words_cnt_next  = '0;
              frame_done_next = 1'b1;
            end else begin
              words_cnt_next = words_sum;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [AW-1:0] ram_waddr;
  logic          ram_we;
  assign ram_waddr = idx_reg + AW'(beat_reg);
  assign ram_we    = w_hs && !err_reg;

  fb_ram #(.DEPTH(DEPTH)) u_ram (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (axi.WDATA),
    .re      (rd_en),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

  assign axi.AWREADY = awready_reg;
  assign axi.WREADY  = wready_reg;
  assign axi.BVALID  = bvalid_reg;
  assign axi.BRESP   = bresp_reg;
  assign frame_done  = frame_done_reg;
endmodule

// File: tb/tb_axi_frame_buffer_slave.sv
// Randomised bench for axi_frame_buffer_slave with a transaction-level reference model.
module tb_axi_frame_buffer_slave;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          FRAME = 64;

  logic        ACLK;
  logic        ARESETn;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic        frame_done;

  axi_fb_if axi_bus ();

  axi_frame_buffer_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .FRAME_WORDS(FRAME)) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .axi        (axi_bus),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_done (frame_done)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  int          phase;      // 0 address wait, 1 data beats, 2 response
  int          idle_cnt;   // clock edges spent in address-wait phase
  int          cur_idx, cur_len, cur_beat;
  bit          cur_err, fin, mism;
  logic [1:0]  exp_resp;
  int          words_m;
  logic [31:0] exp_rd;
  bit          exp_rd_known;
  logic        exp_fd;
  longint      a;

  initial begin
    phase = 0; idle_cnt = 0; words_m = 0;
    exp_rd = '0; exp_rd_known = 1'b1; exp_fd = 1'b0; exp_resp = 2'b00;
    cur_idx = 0; cur_len = 0; cur_beat = 0; cur_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        chk("rst_awready", 32'(axi_bus.AWREADY), 32'd0);
        chk("rst_wready", 32'(axi_bus.WREADY), 32'd0);
        chk("rst_bvalid", 32'(axi_bus.BVALID), 32'd0);
        chk("rst_bresp", 32'(axi_bus.BRESP), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        phase = 0; idle_cnt = 0; words_m = 0;
        exp_rd = '0; exp_rd_known = 1'b1; exp_fd = 1'b0;
      end else begin
        chk("awready", 32'(axi_bus.AWREADY), 32'(phase == 0 && idle_cnt >= 1));
        chk("wready", 32'(axi_bus.WREADY), 32'(phase == 1));
        chk("bvalid", 32'(axi_bus.BVALID), 32'(phase == 2));
        if (phase == 2) chk("bresp", 32'(axi_bus.BRESP), 32'(exp_resp));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        if (exp_rd_known) chk("rd_data", rd_data, exp_rd);
        // predict the effect of the coming clock edge
        if (rd_en) begin
          exp_rd = mem_m[rd_addr];
          exp_rd_known = known_m[rd_addr];
        end
        exp_fd = 1'b0;
        case (phase)
          0: begin
            if (axi_bus.AWVALID && axi_bus.AWREADY) begin
              a = longint'(axi_bus.AWADDR);
              cur_len = int'(axi_bus.AWLEN);
              cur_err = (a < longint'(BASE)) || (a[1:0] != 2'b00) ||
                        (((a - longint'(BASE)) / 4) + cur_len >= DEPTH);
              cur_idx = cur_err ? 0 : int'((a - longint'(BASE)) / 4);
              cur_beat = 0;
              phase = 1;
            end else if (idle_cnt < 2) begin
              idle_cnt++;
            end
          end
          1: begin
            if (axi_bus.WVALID && axi_bus.WREADY) begin
              fin  = axi_bus.WLAST || (cur_beat == cur_len);
              mism = axi_bus.WLAST != (cur_beat == cur_len);
              if (!cur_err) begin
                mem_m[cur_idx + cur_beat]   = axi_bus.WDATA;
                known_m[cur_idx + cur_beat] = !mism;  // disputed last beat: unchecked
              end
              if (fin) begin
                exp_resp = (cur_err || mism) ? 2'b10 : 2'b00;
                phase = 2;
              end
              cur_beat++;
            end
          end
          default: begin
            if (axi_bus.BVALID && axi_bus.BREADY) begin
              if (exp_resp == 2'b00) begin
                words_m += cur_len + 1;
                if (words_m >= FRAME) begin
                  words_m = 0;
                  exp_fd = 1'b1;
                end
              end
              phase = 0;
              idle_cnt = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_burst(input logic [31:0] addr, input int len, input int wl, input int bdelay,
                          input logic [31:0] dbase, input bit gaps,
                          output logic [1:0] resp, output logic fd);
    int n, nb;
    resp = 2'bxx;
    fd = 1'b0;
    axi_bus.AWADDR = addr;
    axi_bus.AWLEN = 8'(len);
    axi_bus.AWVALID = 1'b1;
    n = 0;
    while (!axi_bus.AWREADY && n < 100) begin tick(); n++; end
    if (!axi_bus.AWREADY) begin tmo("aw_wait"); axi_bus.AWVALID = 1'b0; return; end
    tick();
    axi_bus.AWVALID = 1'b0;
    nb = (wl <= len) ? wl + 1 : len + 1;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      axi_bus.WVALID = 1'b1;
      axi_bus.WDATA = dbase + 32'(b);
      axi_bus.WLAST = (b == wl);
      n = 0;
      while (!axi_bus.WREADY && n < 100) begin tick(); n++; end
      if (!axi_bus.WREADY) begin
        tmo("w_wait");
        axi_bus.WVALID = 1'b0; axi_bus.WLAST = 1'b0;
        return;
      end
      tick();
      axi_bus.WVALID = 1'b0;
      axi_bus.WLAST = 1'b0;
    end
    n = 0;
    while (!axi_bus.BVALID && n < 100) begin tick(); n++; end
    if (!axi_bus.BVALID) begin tmo("b_wait"); return; end
    repeat (bdelay) tick();
    resp = axi_bus.BRESP;
    axi_bus.BREADY = 1'b1;
    tick();
    axi_bus.BREADY = 1'b0;
    fd = frame_done;
  endtask

  task automatic read_word(input int idx, output logic [31:0] d);
    rd_en = 1'b1;
    rd_addr = 10'(idx);
    tick();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic pulse_reset();
    ARESETn = 1'b0;
    repeat (2) tick();
    ARESETn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  logic [1:0]  r;
  logic        fd;
  logic [31:0] d;
  int          len, kind, idx, wl;
  bit          rnd_done;
  logic        fd_exp [9];

  initial begin
    ARESETn = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
    axi_bus.AWADDR = '0; axi_bus.AWLEN = '0; axi_bus.AWVALID = 1'b0;
    axi_bus.WDATA = '0; axi_bus.WVALID = 1'b0; axi_bus.WLAST = 1'b0; axi_bus.BREADY = 1'b0;
    rnd_done = 1'b0;
    repeat (3) tick();
    ARESETn = 1'b1;
    tick();

    // 1: basic 16-beat burst and readback
    do_burst(BASE, 15, 15, 0, 32'hABC0_0000, 1'b0, r, fd);
    chk("t1_bresp", 32'(r), 32'h0);
    for (int i = 0; i < 16; i++) begin
      read_word(i, d);
      chk("t1_read", d, 32'hABC0_0000 + 32'(i));
    end

    // 2: burst crossing the top of the buffer is rejected without writing
    do_burst(BASE + 32'(4 * (DEPTH - 8)), 7, 7, 0, 32'h5A5A_0000, 1'b0, r, fd);
    chk("t2_prefill_bresp", 32'(r), 32'h0);
    do_burst(BASE + 32'(4 * (DEPTH - 4)), 7, 7, 0, 32'hDEAD_0000, 1'b0, r, fd);
    chk("t2_bresp", 32'(r), 32'h2);
    for (int i = 0; i < 4; i++) begin
      read_word(DEPTH - 4 + i, d);
      chk("t2_unchanged", d, 32'h5A5A_0004 + 32'(i));
    end

    // 3: early WLAST and missing WLAST
    do_burst(BASE + 32'(4 * 100), 15, 9, 0, 32'h3333_0000, 1'b0, r, fd);
    chk("t3_bresp", 32'(r), 32'h2);
    chk("t3_wready_after", 32'(axi_bus.WREADY), 32'h0);
    read_word(100, d);
    chk("t3_early_beat", d, 32'h3333_0000);
    do_burst(BASE + 32'(4 * 120), 3, 999, 0, 32'h4444_0000, 1'b0, r, fd);
    chk("t3_nolast_bresp", 32'(r), 32'h2);

    // 4: response back-pressure
    do_burst(BASE + 32'(4 * 200), 3, 3, 5, 32'h5555_0000, 1'b0, r, fd);
    chk("t4_bresp", 32'(r), 32'h0);
    chk("t4_awready_gap", 32'(axi_bus.AWREADY), 32'h0);
    tick();
    chk("t4_awready_back", 32'(axi_bus.AWREADY), 32'h1);

    // read-first: hold a read on word 0 while it is rewritten
    fork
      do_burst(BASE, 3, 3, 0, 32'hA0A0_0000, 1'b0, r, fd);
      begin
        rd_en = 1'b1; rd_addr = '0;
        repeat (6) tick();
        rd_en = 1'b0;
      end
    join

    // 5: frame completion pulses
    pulse_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      do_burst(BASE + 32'(4 * (300 + 16 * i)), 15, 15, 0, 32'h6000_0000, 1'b0, r, fd);
      chk("t5_fd_4burst", 32'(fd), 32'(i == 3));
    end
    fd_exp[0] = 0; fd_exp[1] = 0; fd_exp[2] = 0; fd_exp[3] = 0; fd_exp[4] = 1;
    for (int i = 0; i < 5; i++) begin
      do_burst((i == 2) ? BASE + 32'd2 : BASE + 32'(4 * (400 + 16 * i)), 15, 15, 0,
               32'h6100_0000, 1'b0, r, fd);
      chk("t5_fd_with_err", 32'(fd), 32'(fd_exp[i]));
    end

    // 6: reset during beat 5 of a burst
    axi_bus.AWADDR = BASE + 32'(4 * 500); axi_bus.AWLEN = 8'd15; axi_bus.AWVALID = 1'b1;
    for (int n = 0; n < 100 && !axi_bus.AWREADY; n++) tick();
    if (!axi_bus.AWREADY) tmo("t6_aw");
    tick();
    axi_bus.AWVALID = 1'b0;
    for (int b = 0; b < 5; b++) begin
      axi_bus.WVALID = 1'b1; axi_bus.WDATA = 32'h6666_0000 + 32'(b); axi_bus.WLAST = 1'b0;
      tick();
    end
    axi_bus.WDATA = 32'h6666_0005;
    ARESETn = 1'b0;
    #1;
    chk("t6_bvalid_rst", 32'(axi_bus.BVALID), 32'h0);
    chk("t6_wready_rst", 32'(axi_bus.WREADY), 32'h0);
    axi_bus.WVALID = 1'b0;
    repeat (3) tick();
    ARESETn = 1'b1;
    repeat (4) begin
      tick();
      chk("t6_bvalid_after", 32'(axi_bus.BVALID), 32'h0);
    end
    read_word(502, d);
    chk("t6_kept_word", d, 32'h6666_0002);
    do_burst(BASE + 32'(4 * 500), 15, 15, 0, 32'h7777_0000, 1'b0, r, fd);
    chk("t6_next_bresp", 32'(r), 32'h0);
    read_word(515, d);
    chk("t6_next_word", d, 32'h7777_000F);

    // random traffic with a concurrent random reader
    fork
      begin
        for (int t = 0; t < 40; t++) begin
          len = $urandom_range(0, 15);
          kind = $urandom_range(0, 9);
          idx = $urandom_range(0, DEPTH - 1 - len);
          wl = len;
          case (kind)
            0: d = BASE + 32'(4 * idx) + 32'd2;
            1: d = 32'($urandom_range(0, 32'hFFC)) & 32'hFFFF_FFFC;
            2: d = BASE + 32'(4 * (DEPTH - 1 - len + $urandom_range(1, len + 1)));
            3: begin
              d = BASE + 32'(4 * idx);
              wl = (len > 0) ? $urandom_range(0, len - 1) : 999;
            end
            default: d = BASE + 32'(4 * idx);
          endcase
          do_burst(d, len, wl, $urandom_range(0, 3), $urandom, 1'b1, r, fd);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rd_en = 1'($urandom_range(0, 1));
          rd_addr = 10'($urandom_range(0, DEPTH - 1));
          tick();
        end
        rd_en = 1'b0;
      end
    join

    for (int i = 0; i < 64; i++) read_word($urandom_range(0, DEPTH - 1), d);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
